// File: rtl/pool_ctrl_pkg.sv
// Shared constants and FSM encoding for the conv/pool controllers.
package pool_ctrl_pkg;

  localparam int unsigned OFMAP_BASE = 131072;
  localparam int unsigned POOL_BASE  = 196608;

  typedef enum logic [3:0] {
    StIdle = 4'b0001,
    StRd   = 4'b0010,
    StWr   = 4'b0100,
    StDone = 4'b1000
  } state_e;

endpackage

// File: rtl/max_cmp.sv
// Signed two-input maximum; ties return the (equal) second operand.
module max_cmp #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_max
);

  assign o_max = ($signed(i_a) > $signed(i_b)) ? i_a : i_b;

endmodule

// File: rtl/pool_ctrl.sv
// 2x2 max-pool controller: reads each ofmap window from DRAM and writes its signed maximum.
module pool_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  enable,
  input  logic [5:0]            ofmap_width,
  input  logic [5:0]            ofmap_height,
  input  logic [5:0]            num_chnls,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  dram_en_rd,
  output logic                  dram_en_wr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  done
);
  import pool_ctrl_pkg::*;

  state_e                r_state, w_state_nxt;
  logic [1:0]            r_k;
  logic [4:0]            r_px, r_py, r_pw, r_ph;
  logic [5:0]            r_chnl, r_nc;
  logic [DATA_WIDTH-1:0] r_max, w_max;
  logic                  w_geom_bad, w_px_last, w_py_last, w_chnl_last, w_last;
  logic [13:0]           w_rd_ofs, w_wr_ofs;

  assign w_geom_bad  = (ofmap_width < 6'd2) | (ofmap_height < 6'd2) | (num_chnls == 6'd0);
  assign w_px_last   = (r_px == r_pw - 5'd1);
  assign w_py_last   = (r_py == r_ph - 5'd1);
  assign w_chnl_last = (r_chnl == r_nc - 6'd1);
  assign w_last      = w_px_last & w_py_last & w_chnl_last;

  // k[0] selects the column and k[1] the row inside the 2x2 window.
  assign w_rd_ofs = {r_chnl[3:0], r_py[3:0], r_k[1], r_px[3:0], r_k[0]};
  assign w_wr_ofs = {r_chnl[3:0], r_py, r_px};

  max_cmp #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_max_cmp (
    .i_a  (r_max),
    .i_b  (data_in),
    .o_max(w_max)
  );

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    addr_in     = '0;
    addr_out    = '0;
    dram_en_rd  = 1'b0;
    dram_en_wr  = 1'b0;
    data_out    = '0;
    done        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (enable) w_state_nxt = w_geom_bad ? StDone : StRd;
      end
      StRd: begin
        dram_en_rd = 1'b1;
        addr_in    = ADDR_WIDTH'(OFMAP_BASE) + ADDR_WIDTH'(w_rd_ofs);
        if (r_k == 2'd3) w_state_nxt = StWr;
      end
      StWr: begin
        dram_en_wr  = 1'b1;
        addr_out    = ADDR_WIDTH'(POOL_BASE) + ADDR_WIDTH'(w_wr_ofs);
        data_out    = w_max;
        w_state_nxt = w_last ? StDone : StRd;
      end
      StDone: begin
        done        = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      r_k    <= 2'd0;
      r_px   <= 5'd0;
      r_py   <= 5'd0;
      r_chnl <= 6'd0;
      r_pw   <= 5'd0;
      r_ph   <= 5'd0;
      r_nc   <= 6'd0;
      r_max  <= '0;
    end else begin
      if (r_state == StIdle && enable) begin
        r_pw   <= ofmap_width[5:1];
        r_ph   <= ofmap_height[5:1];
        r_nc   <= num_chnls;
        r_k    <= 2'd0;
        r_px   <= 5'd0;
        r_py   <= 5'd0;
        r_chnl <= 6'd0;
        r_max  <= '0;
      end
      if (r_state == StRd) begin
        r_k <= r_k + 2'd1;
        // data_in lags the address by one cycle, so k=1 carries the first window word.
        if (r_k == 2'd1) r_max <= data_in;
        else if (r_k[1]) r_max <= w_max;
      end
      if (r_state == StWr) begin
        if (w_px_last) begin
          r_px <= 5'd0;
          if (w_py_last) begin
            r_py   <= 5'd0;
            r_chnl <= r_chnl + 6'd1;
          end else begin
            r_py <= r_py + 5'd1;
          end
        end else begin
          r_px <= r_px + 5'd1;
        end
      end
    end
  end

endmodule
